// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: small FIFO feeding a tick-paced serializer, line idles high.
// Start bit appears one cycle after the first tick with data queued; writes to a full FIFO are dropped.
module uart_tx_buffered #(
   parameter int DataWidth      = 8,
   parameter int OverSampleRate = 16,
   parameter int FifoDepth      = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 tick_i,
   input  logic                 wr_en_i,
   input  logic [DataWidth-1:0] data_i,
   output logic                 tx_o,
   output logic                 full_o,
   output logic                 empty_o,
   output logic                 busy_o
);
   localparam int AW = $clog2(FifoDepth);
   localparam int CW = $clog2(OverSampleRate);
   localparam int IW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
   localparam logic [CW-1:0] CntLast   = CW'(OverSampleRate - 1);
   localparam logic [IW-1:0] IdxLast   = IW'(DataWidth - 1);
   localparam logic [AW:0]   FullCount = (AW+1)'(FifoDepth);
   localparam logic [AW:0]   PtrLast   = (AW+1)'(FifoDepth - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_next;

   logic [DataWidth-1:0] mem [FifoDepth];
   logic [AW:0]          wr_ptr, rd_ptr, count;
   logic                 push, pop, bit_end, tx_next;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic [DataWidth-1:0] shift, shift_next;

   assign full_o  = (count == FullCount);
   assign empty_o = (count == '0);
   assign busy_o  = (state != IDLE) || !empty_o;
   assign push    = wr_en_i && !full_o;
   assign bit_end = tick_i && (cnt == CntLast);

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr[AW-1:0]] <= data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PtrLast) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PtrLast) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (tick_i && !empty_o) state_next = START;
         START:   if (bit_end) state_next = DATA;
         DATA:    if (bit_end && idx == IdxLast) state_next = STOP;
         STOP:    if (bit_end) state_next = empty_o ? IDLE : START;
         default: state_next = IDLE;
      endcase
   end

   // tx_next is derived from the next state so the line flop changes on the same edge as the FSM.
   always_comb begin
      pop        = 1'b0;
      shift_next = shift;
      case (state)
         IDLE: if (tick_i && !empty_o) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr[AW-1:0]];
         end
         DATA: if (bit_end) shift_next = shift >> 1;
         STOP: if (bit_end && !empty_o) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr[AW-1:0]];
         end
         default: ;
      endcase
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tx_o  <= 1'b1;
         shift <= '0;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         tx_o  <= tx_next;
         shift <= shift_next;
         if (tick_i) begin
            if (state == IDLE || bit_end) cnt <= '0;
            else                          cnt <= cnt + 1'b1;
            if (state == START && bit_end)     idx <= '0;
            else if (state == DATA && bit_end) idx <= idx + 1'b1;
         end
      end
   end
endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered 8N1 UART transmitter: accepts bytes from the bus-side controller into a small FIFO, serializes them LSB-first with one start and one stop bit, and paces every bit from the shared baud generator's oversample tick. It is the transmit counterpart of the UART receiver inside the UART controller. Its `busy_o` feeds the baud generator's TX-busy input.

## Interface
- `DataWidth`, default 8: data bits per frame.
- `OverSampleRate`, default 16: `tick_i` pulses per bit period; range 2..255.
- `FifoDepth`, default 4: FIFO entries; power of two, at least 2.
- `clk_i`, in, 1: system clock, single clock domain.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `tick_i`, in, 1: one-cycle pulse at OverSampleRate × baud, from the baud generator.
- `wr_en_i`, in, 1: push `data_i` into the FIFO.
- `data_i`, in, DataWidth: byte to transmit.
- `tx_o`, out, 1: serial line, idle high.
- `full_o`, out, 1: FIFO holds FifoDepth entries.
- `empty_o`, out, 1: FIFO holds 0 entries.
- `busy_o`, out, 1: frame in progress or FIFO non-empty.

## Operation
- FIFO:
  - Write pointer, read pointer and count, each log2(FifoDepth)+1 bits.
  - Pointers wrap modulo FifoDepth.
  - A write is accepted only if `full_o` is low in that cycle. A write while full is dropped silently, even if a pop happens in the same cycle.
  - A write and a pop in the same cycle leave the count unchanged.
- Transmit FSM, all state changes qualified by `tick_i`:
  - IDLE: `tx_o`=1. On a tick with the FIFO non-empty: pop the head into the shift register, clear the tick counter, go to START.
  - START: `tx_o`=0. On the OverSampleRate-th tick: go to DATA with bit index 0.
  - DATA: `tx_o`=shift[0]. Every OverSampleRate ticks: shift right and increment the index. After bit DataWidth-1 completes, go to STOP.
  - STOP: `tx_o`=1. On the OverSampleRate-th tick:
    - FIFO non-empty: pop, reload, go directly to START (back-to-back frames, no idle gap).
    - FIFO empty: go to IDLE.
- Tick counter: counts 0..OverSampleRate-1 and wraps. A bit ends on the tick where the counter equals OverSampleRate-1.
- Without `tick_i` pulses, the FSM, counter and `tx_o` hold. FIFO writes still proceed.
- `busy_o` = (state != IDLE) | !`empty_o`.
- `tx_o` is driven from a flop: no glitches, no combinational path from the inputs.

## Timing
- Reset, in the cycle after `rst_i` is sampled high:
  - `tx_o`=1, `full_o`=0, `empty_o`=1, `busy_o`=0.
  - State IDLE; pointers, count, tick counter and bit index cleared.
  - FIFO contents discarded.
- Reset mid-frame: the line returns high the next cycle. The partial frame is abandoned, never resumed.
- Write to status:
  - `empty_o` falls and `busy_o` rises one cycle after the accepted write.
  - `full_o` rises one cycle after the write that fills the FIFO.
- Start latency: `tx_o` falls one cycle after the first `tick_i` pulse at which the FIFO is non-empty. The pop occurs on that same edge.
- Frame length: exactly (DataWidth+2) × OverSampleRate tick periods.
- Back-to-back frames: the start bit follows the stop bit with zero extra ticks.
- `full_o` falls one cycle after a pop from a full FIFO. A write in the cycle where `full_o` has fallen is accepted.
- `busy_o` falls one cycle after the final stop-bit tick, provided the FIFO is empty.

## Test plan
- Single byte, `tick_i` every 4 cycles, OverSampleRate=16:
  - Write 0xA5.
  - `tx_o` must be 0 for 64 cycles, then data bits 1,0,1,0,0,1,0,1 for 64 cycles each, then stop 1.
  - `busy_o` must fall after 640 cycles.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles.
  - Two contiguous 160-tick frames with no idle ticks between them.
  - `empty_o` rises on the pop of 0xFF.
- Overflow, `tick_i` held low: write 0x11, 0x22, 0x33, 0x44, 0x55.
  - `full_o` must rise after the fourth write; 0x55 is dropped.
  - Enabling ticks transmits exactly 0x11..0x44.
- Pop with a write when full:
  - Write while full in the same cycle as the IDLE pop: the data is dropped.
  - Write the next cycle: the data is accepted and transmitted last.
- Reset mid-frame: assert `rst_i` during data bit 3 of 0xC3.
  - `tx_o`=1, `empty_o`=1, `busy_o`=0 the next cycle.
  - A new write of 0x3C afterwards transmits a clean frame.
- Tick stall: hold `tick_i` low for 100 cycles mid-stop-bit.
  - `tx_o` stays 1 and the frame resumes with the remaining tick count intact.
